// File: rtl/ram_alu_seq.sv
// ram_alu_seq: vector execution engine. A dual-port synchronous RAM and an
// ALU sit behind a sequencer that computes
//   mem[dst+i] = mem[src_a+i] OP mem[src_b+i]   for i = 0..len-1
// one element every three cycles (RD, EX, WR), then pulses done.
// Optional feature macro: ALU_SAT_EN (signed saturating ADD/SUB).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               begin an operation (sampled only while idle)
//   op, src_a, src_b,   operation code, operand/result base addresses and
//   dst, len            element count; all latched on an accepted start
//   host_we, host_addr, host write/read port, writes honoured only while idle
//   host_wdata
//   host_rdata          host read data, one cycle after host_addr
//   busy                engine active (start accepted, done not yet reached)
//   done                one-cycle completion pulse
//   zero_all            every result of the last operation was zero
module ram_alu_seq #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          busy,
  output logic          done,
  output logic          zero_all
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned SHW   = $clog2(DW);
  localparam int unsigned LW    = AW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EX   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, nxt;

  // Latched operation descriptor and element index
  logic [3:0]    op_q;
  logic [AW-1:0] src_a_q, src_b_q, dst_q;
  logic [AW:0]   len_q;
  logic [AW-1:0] idx;
  logic [DW-1:0] res_q;

  // RAM storage and port signals
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] qa, qb;
  logic [AW-1:0] addr_a_c, addr_b_c;
  logic [DW-1:0] wdata_a_c;
  logic          we_a_c;

  // Sequencer strobes
  logic          accept_c;
  logic          res_en_c;
  logic          idx_inc_c;
  logic          last_c;

  logic [DW-1:0] alu_c;
  logic [DW-1:0] add_c, sub_c;
  logic [SHW-1:0] sh_c;

  assign last_c = (LW'(idx) == (len_q - LW'(1)));
  assign sh_c   = qb[SHW-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic and RAM port steering
  always_comb begin
    nxt       = state;
    accept_c  = 1'b0;
    res_en_c  = 1'b0;
    idx_inc_c = 1'b0;
    we_a_c    = 1'b0;
    addr_a_c  = host_addr;
    wdata_a_c = host_wdata;
    addr_b_c  = host_addr;
    case (state)
      S_IDLE: begin
        we_a_c = host_we;
        if (start) begin
          accept_c = 1'b1;
          nxt      = (len == '0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        addr_a_c = src_a_q + idx;
        addr_b_c = src_b_q + idx;
        nxt      = S_EX;
      end
      S_EX: begin
        res_en_c = 1'b1;
        nxt      = S_WR;
      end
      S_WR: begin
        addr_a_c  = dst_q + idx;
        wdata_a_c = res_q;
        we_a_c    = 1'b1;
        if (last_c) begin
          nxt = S_DONE;
        end else begin
          idx_inc_c = 1'b1;
          nxt       = S_RD;
        end
      end
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Port A: engine read/write or host write; read returns old data
  always_ff @(posedge clk) begin
    if (we_a_c) mem[addr_a_c] <= wdata_a_c;
    qa <= mem[addr_a_c];
  end

  // Port B read register doubles as host_rdata, so it is reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) qb <= '0;
    else     qb <= mem[addr_b_c];
  end

  assign host_rdata = qb;

`ifdef ALU_SAT_EN
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  // One extra sign bit exposes signed overflow: top two bits disagree
  logic [DW:0] sum_ext, dif_ext;
  assign sum_ext = {qa[DW-1], qa} + {qb[DW-1], qb};
  assign dif_ext = {qa[DW-1], qa} - {qb[DW-1], qb};

  always_comb begin
    add_c = sum_ext[DW-1:0];
    sub_c = dif_ext[DW-1:0];
    if (sum_ext[DW] != sum_ext[DW-1]) add_c = sum_ext[DW] ? SMIN : SMAX;
    if (dif_ext[DW] != dif_ext[DW-1]) sub_c = dif_ext[DW] ? SMIN : SMAX;
  end
`else
  assign add_c = qa + qb;
  assign sub_c = qa - qb;
`endif

  // ALU on the two read words; unused op codes yield zero
  always_comb begin
    alu_c = '0;
    case (op_q)
      OP_ADD:  alu_c = add_c;
      OP_SUB:  alu_c = sub_c;
      OP_AND:  alu_c = qa & qb;
      OP_OR:   alu_c = qa | qb;
      OP_XOR:  alu_c = qa ^ qb;
      OP_NOT:  alu_c = ~qa;
      OP_SLL:  alu_c = qa << sh_c;
      OP_SRL:  alu_c = qa >> sh_c;
      OP_SRA:  alu_c = DW'($signed(qa) >>> sh_c);
      OP_SLT:  alu_c = DW'($signed(qa) < $signed(qb));
      OP_PASS: alu_c = qb;
      default: alu_c = '0;
    endcase
  end

  // Datapath registers and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      res_q    <= '0;
      zero_all <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (accept_c) begin
        op_q     <= op;
        src_a_q  <= src_a;
        src_b_q  <= src_b;
        dst_q    <= dst;
        len_q    <= len;
        idx      <= '0;
        zero_all <= 1'b1;
      end
      if (res_en_c) begin
        res_q <= alu_c;
        if (alu_c != '0) zero_all <= 1'b0;
      end
      if (idx_inc_c) idx <= idx + AW'(1);
      // busy tracks the engine state one cycle ahead; done follows DONE
      busy <= (nxt != S_IDLE);
      done <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_ram_alu_seq.sv
// Testbench for ram_alu_seq: randomized and directed operations checked
// against an array-based model of the RAM and the ALU rules.
module tb_ram_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [7:0]  src_a, src_b, dst;
  logic [8:0]  len;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        busy, done, zero_all;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ref_mem [256];
  logic        ref_zero;

  ram_alu_seq #(.DW(16), .AW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .dst(dst), .len(len),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .busy(busy), .done(done), .zero_all(zero_all)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(input int opc, input int a, input int b);
    int sa, sb, r;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    case (opc)
      0: begin
        r = sa + sb;
`ifdef ALU_SAT_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
      end
      1: begin
        r = sa - sb;
`ifdef ALU_SAT_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: r = a << (b % 16);
      7: r = a >> (b % 16);
      8: r = sa >>> (b % 16);
      9: r = (sa < sb) ? 1 : 0;
      10: r = b;
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  // Sequential element-by-element execution with wrapping addresses
  task automatic ref_exec(input int opc, input int a, input int b, input int d, input int n);
    logic [15:0] r;
    ref_zero = 1'b1;
    for (int i = 0; i < n; i++) begin
      r = ref_alu(opc, int'(ref_mem[(a + i) % 256]), int'(ref_mem[(b + i) % 256]));
      ref_mem[(d + i) % 256] = r;
      if (r != 16'h0) ref_zero = 1'b0;
    end
  endtask

  task automatic host_write(input int addr, input logic [15:0] data);
    host_addr  = 8'(addr);
    host_wdata = data;
    host_we    = 1'b1;
    @(posedge clk); #1;
    host_we    = 1'b0;
    ref_mem[addr % 256] = data;
  endtask

  task automatic host_read(input int addr, output logic [15:0] data);
    host_addr = 8'(addr);
    @(posedge clk); #1;
    data = host_rdata;
  endtask

  // Issue one start and count edges until done (cyc = -1 on timeout)
  task automatic run_op(input int opc, input int a, input int b, input int d, input int n,
                        output int cyc, output logic busy_first, output logic busy_at_done);
    op = 4'(opc); src_a = 8'(a); src_b = 8'(b); dst = 8'(d); len = 9'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_first   = busy;
    busy_at_done = 1'bx;
    cyc = -1;
    for (int k = 1; k <= 3 * n + 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = k;
        busy_at_done = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0; len = '0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (zero_all !== 1'b0) begin n_fail++; $display("FAIL reset_zero_all: got %b expected 0", zero_all); end
    n_checks++; if (host_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0000", host_rdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 256; a++) host_write(a, 16'($urandom));
  endtask

  task automatic test_add_basic();
    int cyc; logic bf, bd; logic [15:0] rd;
    host_write(8'h10, 16'h0003);
    host_write(8'h20, 16'h0004);
    run_op(0, 8'h10, 8'h20, 8'h30, 1, cyc, bf, bd);
    ref_exec(0, 8'h10, 8'h20, 8'h30, 1);
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL add_done_latency: got %0d expected 4", cyc); end
    n_checks++; if (bf !== 1'b1) begin n_fail++; $display("FAIL add_busy_rise: got %b expected 1", bf); end
    n_checks++; if (bd !== 1'b0) begin n_fail++; $display("FAIL add_busy_fall: got %b expected 0", bd); end
    n_checks++; if (zero_all !== 1'b0) begin n_fail++; $display("FAIL add_zero_all: got %b expected 0", zero_all); end
    host_read(8'h30, rd);
    n_checks++; if (rd !== 16'h0007) begin n_fail++; $display("FAIL add_result: got %h expected 0007", rd); end
  endtask

  task automatic test_and_zero();
    int cyc; logic bf, bd; logic [15:0] rd;
    for (int i = 0; i < 4; i++) begin
      host_write(8'h40 + i, 16'hFFFF);
      host_write(8'h50 + i, 16'h0000);
    end
    run_op(2, 8'h40, 8'h50, 8'h60, 4, cyc, bf, bd);
    ref_exec(2, 8'h40, 8'h50, 8'h60, 4);
    n_checks++; if (cyc !== 13) begin n_fail++; $display("FAIL and_done_latency: got %0d expected 13", cyc); end
    n_checks++; if (zero_all !== 1'b1) begin n_fail++; $display("FAIL and_zero_all: got %b expected 1", zero_all); end
    for (int i = 0; i < 4; i++) begin
      host_read(8'h60 + i, rd);
      n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL and_result[%0d]: got %h expected 0000", i, rd); end
    end
  endtask

  task automatic test_overlap_wrap();
    int cyc; logic bf, bd; logic [15:0] rd;
    host_write(8'hFE, 16'h1234);
    host_write(8'hFF, 16'h5555);
    host_write(8'h00, 16'h6666);
    host_write(8'h01, 16'h7777);
    run_op(10, 8'hFE, 8'hFE, 8'hFF, 3, cyc, bf, bd);
    ref_exec(10, 8'hFE, 8'hFE, 8'hFF, 3);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL wrap_done_latency: got %0d expected 10", cyc); end
    for (int i = 0; i < 3; i++) begin
      host_read((8'hFF + i) % 256, rd);
      n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL wrap_result[%0d]: got %h expected 1234", i, rd); end
    end
  endtask

  task automatic test_saturation();
    int cyc; logic bf, bd; logic [15:0] rd, e_add, e_sub;
`ifdef ALU_SAT_EN
    e_add = 16'h7FFF; e_sub = 16'h8000;
`else
    e_add = 16'h8000; e_sub = 16'h7FFF;
`endif
    host_write(8'h70, 16'h7FFF);
    host_write(8'h71, 16'h0001);
    host_write(8'h72, 16'h8000);
    run_op(0, 8'h70, 8'h71, 8'h74, 1, cyc, bf, bd);
    ref_exec(0, 8'h70, 8'h71, 8'h74, 1);
    run_op(1, 8'h72, 8'h71, 8'h75, 1, cyc, bf, bd);
    ref_exec(1, 8'h72, 8'h71, 8'h75, 1);
    host_read(8'h74, rd);
    n_checks++; if (rd !== e_add) begin n_fail++; $display("FAIL sat_add: got %h expected %h", rd, e_add); end
    host_read(8'h75, rd);
    n_checks++; if (rd !== e_sub) begin n_fail++; $display("FAIL sat_sub: got %h expected %h", rd, e_sub); end
  endtask

  task automatic test_reset_midop();
    int cyc; logic bf, bd; logic [15:0] rd;
    op = 4'd0; src_a = 8'h80; src_b = 8'h90; dst = 8'hA0; len = 9'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
    // Only element 0 has completed its write cycle before the reset
    ref_exec(0, 8'h80, 8'h90, 8'hA0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      host_read(8'hA0 + i, rd);
      n_checks++; if (rd !== ref_mem[8'hA0 + i]) begin n_fail++; $display("FAIL midrst_mem[%0d]: got %h expected %h", i, rd, ref_mem[8'hA0 + i]); end
    end
    run_op(4, 8'h80, 8'h90, 8'hA8, 2, cyc, bf, bd);
    ref_exec(4, 8'h80, 8'h90, 8'hA8, 2);
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL midrst_next_latency: got %0d expected 7", cyc); end
    for (int i = 0; i < 2; i++) begin
      host_read(8'hA8 + i, rd);
      n_checks++; if (rd !== ref_mem[8'hA8 + i]) begin n_fail++; $display("FAIL midrst_next[%0d]: got %h expected %h", i, rd, ref_mem[8'hA8 + i]); end
    end
  endtask

  task automatic test_len0_ignore();
    int cyc; logic bf, bd; logic [15:0] rd;
    run_op(3, 8'h10, 8'h20, 8'hB4, 0, cyc, bf, bd);
    n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL len0_latency: got %0d expected 1", cyc); end
    n_checks++; if (zero_all !== 1'b1) begin n_fail++; $display("FAIL len0_zero_all: got %b expected 1", zero_all); end
    host_read(8'hB4, rd);
    n_checks++; if (rd !== ref_mem[8'hB4]) begin n_fail++; $display("FAIL len0_mem: got %h expected %h", rd, ref_mem[8'hB4]); end
    // Real op on C0..C3, with a stray start and host write while busy
    op = 4'd4; src_a = 8'hB0; src_b = 8'hB8; dst = 8'hC0; len = 9'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    op = 4'd10; dst = 8'hD0; len = 9'd1;
    start = 1'b1;
    host_we = 1'b1; host_addr = 8'hC8; host_wdata = 16'hDEAD;
    @(posedge clk); #1;
    start = 1'b0; host_we = 1'b0;
    ref_exec(4, 8'hB0, 8'hB8, 8'hC0, 4);
    cyc = -1;
    for (int k = 3; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin cyc = k; break; end
    end
    n_checks++; if (cyc !== 13) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 13", cyc); end
    for (int i = 0; i < 4; i++) begin
      host_read(8'hC0 + i, rd);
      n_checks++; if (rd !== ref_mem[8'hC0 + i]) begin n_fail++; $display("FAIL ignore_result[%0d]: got %h expected %h", i, rd, ref_mem[8'hC0 + i]); end
    end
    host_read(8'hC8, rd);
    n_checks++; if (rd !== ref_mem[8'hC8]) begin n_fail++; $display("FAIL ignore_host_we: got %h expected %h", rd, ref_mem[8'hC8]); end
    host_read(8'hD0, rd);
    n_checks++; if (rd !== ref_mem[8'hD0]) begin n_fail++; $display("FAIL ignore_start: got %h expected %h", rd, ref_mem[8'hD0]); end
  endtask

  task automatic test_back_to_back();
    int c1, c2; logic bf, bd; logic [15:0] rd;
    run_op(0, 8'h30, 8'h31, 8'hE0, 3, c1, bf, bd);
    ref_exec(0, 8'h30, 8'h31, 8'hE0, 3);
    // Start in the done cycle: first IDLE cycle after DONE
    run_op(7, 8'hE0, 8'h40, 8'hE4, 3, c2, bf, bd);
    ref_exec(7, 8'hE0, 8'h40, 8'hE4, 3);
    n_checks++; if (c1 !== 10) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 10", c1); end
    n_checks++; if (c2 !== 10) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 10", c2); end
    for (int i = 0; i < 8; i++) begin
      host_read(8'hE0 + i, rd);
      n_checks++; if (rd !== ref_mem[8'hE0 + i]) begin n_fail++; $display("FAIL b2b_mem[%0d]: got %h expected %h", i, rd, ref_mem[8'hE0 + i]); end
    end
  endtask

  task automatic test_random();
    int cyc, opc, a, b, d, n; logic bf, bd; logic [15:0] rd;
    for (int t = 0; t < 24; t++) begin
      opc = $urandom_range(0, 15);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      d = $urandom_range(0, 255);
      n = $urandom_range(0, 10);
      run_op(opc, a, b, d, n, cyc, bf, bd);
      ref_exec(opc, a, b, d, n);
      n_checks++; if (cyc !== 3 * n + 1) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, cyc, 3 * n + 1); end
      n_checks++; if (zero_all !== ref_zero) begin n_fail++; $display("FAIL rand%0d_zero_all op=%0d: got %b expected %b", t, opc, zero_all, ref_zero); end
      for (int i = 0; i < n; i++) begin
        host_read((d + i) % 256, rd);
        n_checks++;
        if (rd !== ref_mem[(d + i) % 256]) begin
          n_fail++;
          $display("FAIL rand%0d_mem op=%0d addr=%h: got %h expected %h", t, opc, (d + i) % 256, rd, ref_mem[(d + i) % 256]);
        end
      end
    end
  endtask

  task automatic test_full_mem();
    logic [15:0] rd;
    for (int a = 0; a < 256; a++) begin
      host_read(a, rd);
      n_checks++; if (rd !== ref_mem[a]) begin n_fail++; $display("FAIL full_mem addr=%h: got %h expected %h", a, rd, ref_mem[a]); end
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_and_zero();
    test_overlap_wrap();
    test_saturation();
    test_reset_midop();
    test_len0_ignore();
    test_back_to_back();
    test_random();
    test_full_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_alu_seq.md
# ram_alu_seq

Parametrised vector execution engine for the datapath. It holds a dual-port synchronous RAM and an ALU behind a sequencing state machine. On `start` it computes `mem[dst+i] = mem[src_a+i] OP mem[src_b+i]` for `i = 0..len-1`, then pulses `done`. A host port loads and inspects RAM while the engine is idle, so it replaces the fixed 8-bit-address, 16-bit-data single-operation control/ALU/RAM arrangement.

## Interface
Parameters:
- `DW`, 16, data word width (≥ 8)
- `AW`, 8, address width; RAM depth = 2^AW words

Ports:
- `clk`  in  1  clock, all logic on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin an operation; sampled only in IDLE
- `op`  in  4  ALU operation code, latched on start
- `src_a`  in  AW  base address of operand A, latched on start
- `src_b`  in  AW  base address of operand B, latched on start
- `dst`  in  AW  base address of the result, latched on start
- `len`  in  AW+1  element count, 0..2^AW, latched on start
- `host_we`  in  1  host write strobe; honoured only when `busy`=0
- `host_addr`  in  AW  host address
- `host_wdata`  in  DW  host write data
- `host_rdata`  out  DW  host read data, one cycle after `host_addr`
- `busy`  out  1  high from the cycle after start is accepted until DONE exits
- `done`  out  1  one-cycle pulse when the operation completes
- `zero_all`  out  1  1 if every result of the last operation was 0

## Operation
- RAM: port A is used by the engine (read and write) or by the host write. Port B is used for engine reads or host reads. Both ports have 1-cycle synchronous read latency. RAM contents are not reset.
- States and transitions:
  - IDLE: on `start`, latch all inputs, clear the element index `i`, set `zero_all`=1. If `len`=0 go to DONE, else go to RD.
  - RD: drive port A with `src_a+i` and port B with `src_b+i`, then go to EX.
  - EX: register the ALU result from the two read words. If the result is nonzero, clear `zero_all`. Go to WR.
  - WR: write the result to `dst+i` through port A. If `i`=`len`-1 go to DONE; else increment `i` and go to RD.
  - DONE: `done`=1, then go to IDLE.
- Address sums wrap modulo 2^AW.
- Overlapping regions are legal. Element i is fully written before element i+1 is read, so strict sequential semantics hold.
- Op codes (all results are DW bits wide):
  - 0 ADD
  - 1 SUB (A−B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SLL, A << B[log2(DW)-1:0]
  - 7 SRL
  - 8 SRA
  - 9 SLT signed: result is 1 or 0
  - 10 PASS B
  - 11..15: result is 0, and the write still occurs
- `start` while busy is ignored. `host_we` while busy is ignored. `host_rdata` while busy is undefined.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `zero_all`=0, `host_rdata`=0.
- With `start` sampled at edge T:
  - `busy` rises after T.
  - `done` is high in the cycle after edge T+3·len+1.
  - For `len`=0, `done` is high after edge T+1.
- `busy` falls together with `done`.
- A new `start` is accepted in the first IDLE cycle after DONE.
- Throughput is 3 cycles per element.
- Reset mid-operation:
  - Return to IDLE immediately; no further writes occur.
  - `busy` and `done` go to 0.
  - Partially written results remain in RAM.
- `zero_all` holds its value until the next accepted `start`.

## Configuration
- `ALU_SAT_EN` defined: ADD and SUB saturate in signed arithmetic, clamping to 2^(DW-1)-1 or −2^(DW-1).
- `ALU_SAT_EN` undefined: ADD and SUB wrap modulo 2^DW.
- All other ops are unaffected by the macro.

## Test plan
- Load 0x0003 at 0x10 and 0x0004 at 0x20 via the host port. Start op=0, src_a=0x10, src_b=0x20, dst=0x30, len=1. Required: `done` 4 cycles after start; host read of 0x30 returns 0x0007; `zero_all`=0.
- len=4, op=2 (AND), operands 0xFFFF and 0x0000 at every element. Required: 4 results of 0, `zero_all`=1, `done` 13 cycles after start.
- Overlap/wrap: src_a=0xFE, dst=0xFF, len=3, op=10 with B=src_a region. Required: results written to 0xFF, 0x00, 0x01 in sequential order, with element 1 reading the value just written to 0xFF.
- Saturation at DW=16: 0x7FFF + 0x0001. Required: 0x7FFF with `ALU_SAT_EN`, 0x8000 without. Also 0x8000 − 0x0001: 0x8000 with, 0x7FFF without.
- Assert `rst` at cycle 5 of a len=8 op. Required: `busy`=0 and `done`=0 immediately; no writes after reset; the next start works normally.
- `len`=0 start: `done` 1 cycle later, no RAM change. `start` and `host_we` pulsed while busy: both ignored.
